// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one 1-bit full-subtractor cell walked LSB-first over WIDTH bits.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH (period WIDTH+2).
// Backpressure: none; start is only sampled in IDLE, ignored (not queued) while RUN/DONE.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only in IDLE
//   a, b   - minuend / subtrahend, captured on the accept edge
//   bin    - borrow-in, captured on the accept edge (only with SERIAL_SUB_BIN_EN)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse; diff/bout valid from this cycle on
//   diff   - a - b - bin_init mod 2^WIDTH, held until the next operation completes
//   bout   - final borrow-out, held like diff
// Build option: define SERIAL_SUB_BIN_EN to add the bin port; otherwise bin_init is 0.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
   input  logic             bin,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_d_sh;
   logic               r_borrow;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_bin_init;
   logic               w_cell_a;
   logic               w_cell_b;
   logic               w_cell_d;
   logic               w_cell_bo;
   logic               w_last;

`ifdef SERIAL_SUB_BIN_EN
   assign w_bin_init = bin;
`else
   assign w_bin_init = 1'b0;
`endif

   // Shared 1-bit full-subtractor cell
   assign w_cell_a  = r_a_sh[0];
   assign w_cell_b  = r_b_sh[0];
   assign w_cell_d  = w_cell_a ^ w_cell_b ^ r_borrow;
   assign w_cell_bo = (~w_cell_a & w_cell_b) | (~(w_cell_a ^ w_cell_b) & r_borrow);

   // cnt holds the index of the bit processed on the current RUN edge
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_d_sh   <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         diff     <= '0;
         bout     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_borrow <= w_bin_init;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_d_sh   <= {w_cell_d, r_d_sh[WIDTH-1:1]};
               r_borrow <= w_cell_bo;
               r_cnt    <= r_cnt + CNT_W'(1);
               // Visible result changes only once the whole word is finished,
               // so the previous result stays readable during a new operation.
               if (w_last) begin
                  diff <= {w_cell_d, r_d_sh[WIDTH-1:1]};
                  bout <= w_cell_bo;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
`ifdef SERIAL_SUB_BIN_EN
   logic       bin;
`endif
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_SUB_BIN_EN
      .bin   (bin),
`endif
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present operands with start=1 and step past the accept edge.
   task automatic go(input logic [7:0] va, input logic [7:0] vb, input logic vbin, input bit hold);
      @(negedge clk);
      a     = va;
      b     = vb;
`ifdef SERIAL_SUB_BIN_EN
      bin   = vbin;
`else
      if (vbin) $display("note: bin ignored in this build");
`endif
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Called in the first cycle after the accept edge; waits (bounded) for done.
   task automatic wait_done(input string tag, input logic [7:0] ed, input logic eb);
      int cyc;
      int nbusy;
      cyc   = 1;
      nbusy = 0;
      while (!done && cyc < 40) begin
         if (busy) nbusy++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_lat"},     cyc,   9);
      chk({tag, "_busycyc"}, nbusy, 8);
      chk({tag, "_busy@done"}, {31'd0, busy}, 0);
      chk({tag, "_diff"},    {24'd0, diff}, {24'd0, ed});
      chk({tag, "_bout"},    {31'd0, bout}, {31'd0, eb});
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
`ifdef SERIAL_SUB_BIN_EN
      bin   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_diff", {24'd0, diff}, 0);
      chk("rst_bout", {31'd0, bout}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic subtraction
      go(8'h05, 8'h03, 1'b0, 1'b0);
      wait_done("t1", 8'h02, 1'b0);
      @(negedge clk);
      chk("t1_done_pulse", {31'd0, done}, 0);

      // Underflow, equal operands, extremes
      go(8'h00, 8'h01, 1'b0, 1'b0);
      wait_done("t2a", 8'hFF, 1'b1);
      go(8'hA5, 8'hA5, 1'b0, 1'b0);
      wait_done("t2b", 8'h00, 1'b0);
      go(8'h00, 8'hFF, 1'b0, 1'b0);
      wait_done("t2c", 8'h01, 1'b1);
      go(8'h80, 8'h7F, 1'b0, 1'b0);
      wait_done("t2d", 8'h01, 1'b0);

      // start held high, operands changed mid-run, back-to-back hold of old result
      go(8'h10, 8'h30, 1'b0, 1'b1);
      a = 8'hFF;
      b = 8'h00;
      wait_done("t3a", 8'hE0, 1'b1);
      @(negedge clk);
      chk("t3_idle_busy", {31'd0, busy}, 0);
      chk("t3_idle_done", {31'd0, done}, 0);
      @(negedge clk);
      chk("t3_reaccept_busy", {31'd0, busy}, 1);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_hold_diff", {24'd0, diff}, 8'hE0);
      chk("t5_hold_bout", {31'd0, bout}, 1);
      // re-enter wait_done's frame: we are 4 cycles after the accept edge
      cnt = 4;
      while (!done && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk("t3b_lat", cnt, 9);
      chk("t3b_diff", {24'd0, diff}, 8'hFF);
      chk("t3b_bout", {31'd0, bout}, 0);
      @(negedge clk);

      // Reset in the middle of a run
      go(8'h5A, 8'h21, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_busy", {31'd0, busy}, 0);
      chk("t4_rst_done", {31'd0, done}, 0);
      chk("t4_rst_diff", {24'd0, diff}, 0);
      chk("t4_rst_bout", {31'd0, bout}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      chk("t4_no_done", cnt, 0);
      go(8'h5A, 8'h21, 1'b0, 1'b0);
      wait_done("t4_fresh", 8'h39, 1'b0);

`ifdef SERIAL_SUB_BIN_EN
      go(8'h10, 8'h0F, 1'b1, 1'b0);
      wait_done("t6a", 8'h00, 1'b0);
      go(8'h00, 8'h00, 1'b1, 1'b0);
      wait_done("t6b", 8'hFF, 1'b1);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
